fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit -- two-wide instruction fetch front end.
//
// Issues one 64-bit line request per cycle to a 1-cycle-latency instruction
// memory and buffers returned lines in a small FIFO. The FIFO head drives
// decode directly. A redirect flushes everything and restarts the fetch at
// the 8-byte-aligned target. If the target is the upper word of a line,
// slot 0 of the first line is marked invalid.
//
// Parameters
//   RESET_PC    byte address of the first fetch (8-byte aligned)
//   FIFO_DEPTH  line buffer entries (power of two, >= 2)
// Ports
//   clock_i, reset_n_i       clock, async active-low reset
//   imem_addr_o [9:0]        line address = fetch_pc[12:3]
//   imem_data_i [63:0]       line data, one cycle after its address
//   stall_i                  decode not ready; holds the head line
//   redirect_i, redirect_pc_i  branch/jump redirect
//   instr0_o, instr1_o, pc_o head line slots and base byte address
//   valid_o [1:0]            per-slot valid (bit0 = slot 0)
// Optional (macro FETCH_PERF_CNT_EN)
//   perf_lines_o, perf_stall_o  popped lines / stalled-valid cycles
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clock_i,
   input  logic        reset_n_i,
   output logic [9:0]  imem_addr_o,
   input  logic [63:0] imem_data_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] instr0_o,
   output logic [31:0] instr1_o,
   output logic [31:0] pc_o,
   output logic [1:0]  valid_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_lines_o,
   output logic [31:0] perf_stall_o
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW+1:0] DEPTH_W = (PW+2)'(FIFO_DEPTH);

   typedef struct packed {
      logic [63:0] line;
      logic [31:0] pc;
      logic        ok;    // slot 0 holds a wanted instruction
   } entry_t;

   entry_t        fifo_q [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr_q, wr_ptr_q;
   logic [PW:0]   count_q, count_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   infl_pc_q;
   logic          infl_q, infl_ok_q;
   logic          half_q;   // next issued line starts mid-line (target pc[2]=1)

   logic          pop, wr, issue;
   logic [PW+1:0] occ;

   // Byte-offset bits of the redirect target never matter (4-byte aligned).
   logic unused_rpc;
   assign unused_rpc = ^redirect_pc_i[1:0];

   assign imem_addr_o = fetch_pc_q[12:3];
   assign instr0_o    = fifo_q[rd_ptr_q].line[31:0];
   assign instr1_o    = fifo_q[rd_ptr_q].line[63:32];
   assign pc_o        = fifo_q[rd_ptr_q].pc;

   always_comb begin
      valid_o = 2'b00;
      if (count_q != '0) valid_o = {1'b1, fifo_q[rd_ptr_q].ok};
   end

   assign pop = (valid_o != 2'b00) && !stall_i;
   assign wr  = infl_q;
   assign occ = {1'b0, count_q} + {{(PW+1){1'b0}}, infl_q};
   // Issuing alongside a pop keeps one line per cycle with a full buffer:
   // the slot freed by the pop is reserved for the new request. No issue
   // in a redirect cycle since the presented address is already stale.
   assign issue = !redirect_i && ((occ < DEPTH_W) || pop);

   always_comb begin
      count_d = count_q;
      if (wr && !pop)      count_d = count_q + 1'b1;
      else if (!wr && pop) count_d = count_q - 1'b1;
      fetch_pc_d = issue ? fetch_pc_q + 32'd8 : fetch_pc_q;
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         fetch_pc_q <= RESET_PC;
         infl_q     <= 1'b0;
         infl_ok_q  <= 1'b1;
         infl_pc_q  <= '0;
         half_q     <= 1'b0;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else if (redirect_i) begin
         // Flush; clearing infl_q drops the response of this cycle's request.
         fetch_pc_q <= {redirect_pc_i[31:3], 3'b000};
         half_q     <= redirect_pc_i[2];
         infl_q     <= 1'b0;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         count_q    <= count_d;
         infl_q     <= issue;
         if (wr)  wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (issue) begin
            infl_pc_q <= fetch_pc_q;
            infl_ok_q <= !half_q;
            half_q    <= 1'b0;
         end
      end
   end

   // Buffer storage needs no reset; count_q qualifies every entry.
   always_ff @(posedge clock_i) begin
      if (wr && !redirect_i)
         fifo_q[wr_ptr_q] <= '{line: imem_data_i, pc: infl_pc_q, ok: infl_ok_q};
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_lines_q, perf_stall_q;

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         perf_lines_q <= '0;
         perf_stall_q <= '0;
      end else begin
         if (pop)                                perf_lines_q <= perf_lines_q + 32'd1;
         if ((valid_o != 2'b00) && stall_i)      perf_stall_q <= perf_stall_q + 32'd1;
      end
   end

   assign perf_lines_o = perf_lines_q;
   assign perf_stall_o = perf_stall_q;
`endif

endmodule
